// File: rtl/perf_mon_pkg.sv
// Shared opcodes, retire classes, counter indices and FSM encoding for the
// pipeline performance monitor.
package perf_mon_pkg;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_LD   = 7'h03;
    localparam logic [6:0] OP_SD   = 7'h23;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_ADDI = 7'h13;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LD,
        CLS_SD,
        CLS_BR,
        CLS_ADDI,
        CLS_OTHER
    } instr_class_e;

    localparam int NUM_CLASSES = 6;

    localparam logic [3:0] CNT_CYCLE      = 4'd0;
    localparam logic [3:0] CNT_RETIRED    = 4'd1;
    localparam logic [3:0] CNT_STALL      = 4'd2;
    localparam logic [3:0] CNT_FLUSH      = 4'd3;
    localparam logic [3:0] CNT_TRACE_DROP = 4'd4;
    localparam logic [3:0] CNT_CLS_R      = 4'd5;
    localparam logic [3:0] CNT_CLS_LD     = 4'd6;
    localparam logic [3:0] CNT_CLS_SD     = 4'd7;
    localparam logic [3:0] CNT_CLS_BR     = 4'd8;
    localparam logic [3:0] CNT_CLS_ADDI   = 4'd9;
    localparam logic [3:0] CNT_CLS_OTHER  = 4'd10;

    localparam int NUM_CNT = int'(CNT_CLS_R) + NUM_CLASSES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FROZEN
    } state_e;

    function automatic instr_class_e decode_class(input logic [6:0] opcode);
        case (opcode)
            OP_R:    return CLS_R;
            OP_LD:   return CLS_LD;
            OP_SD:   return CLS_SD;
            OP_BR:   return CLS_BR;
            OP_ADDI: return CLS_ADDI;
            default: return CLS_OTHER;
        endcase
    endfunction

    function automatic logic [3:0] class_to_idx(input instr_class_e cls);
        case (cls)
            CLS_R:    return CNT_CLS_R;
            CLS_LD:   return CNT_CLS_LD;
            CLS_SD:   return CNT_CLS_SD;
            CLS_BR:   return CNT_CLS_BR;
            CLS_ADDI: return CNT_CLS_ADDI;
            default:  return CNT_CLS_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/perf_trace_fifo.sv
// Synchronous first-word-fall-through FIFO for retire trace entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module perf_trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Hardware performance counters and optional retire trace for cpu_pipelined.
// Define PERF_MON_TRACE_EN to build the PC/instruction trace FIFO.
//
//  state  | meaning
//  IDLE   | waiting for run_en, nothing counted
//  RUN    | program executing, all counters active
//  DRAIN  | DRAIN_CYCLES post-end_program cycles still counted
//  FROZEN | counts held until reset, done=1
module pipeline_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int PC_W         = 32,
    parameter int TRACE_DEPTH  = 16,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             end_program,
    input  logic             retire_valid,
    input  logic [PC_W-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_rdata,
    input  logic             trace_rd_en,
    output logic             trace_valid,
    output logic [PC_W+31:0] trace_data,
    output logic             trace_ovf,
    output logic             done
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e           state;
    state_e           state_nxt;
    logic [DRN_W-1:0] drain_cnt;
    logic [DRN_W-1:0] drain_nxt;
    logic             counting;
    logic             trace_drop_evt;
    instr_class_e     retire_cls;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [CNT_W-1:0] rd_mux;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // The drain timer is a down-counter loaded on the end_program cycle;
    // terminal count zero marks the last counted DRAIN cycle.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            IDLE: begin
                if (run_en) state_nxt = RUN;
            end
            RUN: begin
                if (end_program) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_nxt = FROZEN;
                    end else begin
                        state_nxt = DRAIN;
                        drain_nxt = DRN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) state_nxt = FROZEN;
                else                 drain_nxt = drain_cnt - DRN_W'(1);
            end
            FROZEN: begin
                state_nxt = FROZEN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign counting   = (state == RUN) || (state == DRAIN);
    assign done       = (state == FROZEN);
    assign retire_cls = decode_class(retire_instr[6:0]);

`ifdef PERF_MON_TRACE_EN
    logic push_req;
    logic pop_req;
    logic fifo_full;
    logic fifo_empty;
    logic ovf_q;

    assign push_req       = counting && retire_valid;
    assign pop_req        = trace_rd_en && !fifo_empty;
    assign trace_drop_evt = push_req && fifo_full && !pop_req;

    perf_trace_fifo #(
        .WIDTH (PC_W + 32),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (pop_req),
        .wr_data ({retire_pc, retire_instr}),
        .rd_data (trace_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset)              ovf_q <= 1'b0;
        else if (trace_drop_evt) ovf_q <= 1'b1;
    end

    assign trace_valid = !fifo_empty;
    assign trace_ovf   = ovf_q;
`else
    logic unused_trace;

    assign trace_drop_evt = 1'b0;
    assign trace_valid    = 1'b0;
    assign trace_data     = '0;
    assign trace_ovf      = 1'b0;
    assign unused_trace   = ^{trace_rd_en, retire_pc, retire_instr[31:7]};
`endif

    always_comb begin
        cnt_inc = '0;
        if (counting) begin
            cnt_inc[CNT_CYCLE]                = 1'b1;
            cnt_inc[CNT_RETIRED]              = retire_valid;
            cnt_inc[CNT_STALL]                = stall;
            cnt_inc[CNT_FLUSH]                = flush;
            cnt_inc[CNT_TRACE_DROP]           = trace_drop_evt;
            cnt_inc[class_to_idx(retire_cls)] = retire_valid;
        end
    end

    // Saturating counters: an all-ones value holds instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (cnt_inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (cnt_sel <= CNT_CLS_OTHER) rd_mux = cnt[cnt_sel];
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_rdata <= '0;
        else        cnt_rdata <= rd_mux;
    end

endmodule
